// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed seven-segment driver with frame snapshot and blink.
// Define LEADING_ZERO_BLANK_EN to hide slot 5 while the hours-tens digit is zero.
module seg_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYCLES  = 16,
   parameter int BLINK_FRAMES = 80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sec_lo,
   input  logic [7:0] sec_hi,
   input  logic [7:0] min_lo,
   input  logic [7:0] min_hi,
   input  logic [7:0] hr_lo,
   input  logic [7:0] hr_hi,
   input  logic [5:0] blink_mask,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEAD_END = DW'(DEAD_CYCLES);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   logic [DW-1:0] div_cnt;
   logic [2:0]    idx;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic [7:0]    shadow [6];

   logic          slot_end;
   logic          frame_end;
   logic [5:0]    slot_oh;
   logic [7:0]    cur;
   logic          dead;
   logic          blink_off;
   logic          suppress;
   logic          hide;
   logic [6:0]    seg_d;
   logic          dp_d;
   logic [5:0]    an_d;

   function automatic logic [6:0] decode(input logic [7:0] v);
      logic [6:0] s;
      case (v)
         8'd0:    s = 7'h40;
         8'd1:    s = 7'h79;
         8'd2:    s = 7'h24;
         8'd3:    s = 7'h30;
         8'd4:    s = 7'h19;
         8'd5:    s = 7'h12;
         8'd6:    s = 7'h02;
         8'd7:    s = 7'h78;
         8'd8:    s = 7'h00;
         8'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == 3'd5);

   always_comb begin
      slot_oh = 6'b000000;
      cur     = shadow[0];
      unique case (idx)
         3'd0: begin slot_oh = 6'b000001; cur = shadow[0]; end
         3'd1: begin slot_oh = 6'b000010; cur = shadow[1]; end
         3'd2: begin slot_oh = 6'b000100; cur = shadow[2]; end
         3'd3: begin slot_oh = 6'b001000; cur = shadow[3]; end
         3'd4: begin slot_oh = 6'b010000; cur = shadow[4]; end
         3'd5: begin slot_oh = 6'b100000; cur = shadow[5]; end
         default: begin slot_oh = 6'b000000; cur = shadow[0]; end
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   assign suppress = slot_oh[5] && (shadow[5] == 8'd0);
`else
   assign suppress = 1'b0;
`endif

   // dead time at slot start keeps the previous digit from ghosting
   assign dead      = (div_cnt < DEAD_END);
   assign blink_off = blink_phase && |(blink_mask & slot_oh);
   assign hide      = dead || blink_off || suppress;

   assign seg_d = decode(cur);
   assign dp_d  = ~(slot_oh[2] | slot_oh[4]);
   assign an_d  = hide ? 6'h3F : ~slot_oh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         idx     <= 3'd0;
      end else if (slot_end) begin
         div_cnt <= '0;
         idx     <= frame_end ? 3'd0 : idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == FRM_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   // snapshot lands with idx 5->0 so a frame never mixes old and new digits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) shadow[i] <= 8'd0;
      end else if (frame_end) begin
         shadow[0] <= sec_lo;
         shadow[1] <= sec_hi;
         shadow[2] <= min_lo;
         shadow[3] <= min_hi;
         shadow[4] <= hr_lo;
         shadow[5] <= hr_hi;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg <= 7'h7F;
         dp  <= 1'b1;
         an  <= 6'h3F;
      end else begin
         seg <= seg_d;
         dp  <= dp_d;
         an  <= an_d;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: checks seg_scan against a cycle-count model of the scan.
// Directed scenarios plus randomized inputs and blink masks.
module tb_seg_scan;

   localparam int SD = 4;
   localparam int DC = 1;
   localparam int BF = 2;
   localparam int FR = 6 * SD;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] sec_lo = 8'd0;
   logic [7:0] sec_hi = 8'd0;
   logic [7:0] min_lo = 8'd0;
   logic [7:0] min_hi = 8'd0;
   logic [7:0] hr_lo = 8'd0;
   logic [7:0] hr_hi = 8'd0;
   logic [5:0] blink_mask = 6'd0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;

   int checks = 0;
   int errors = 0;

   seg_scan #(
      .SCAN_DIV(SD),
      .DEAD_CYCLES(DC),
      .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sec_lo(sec_lo),
      .sec_hi(sec_hi),
      .min_lo(min_lo),
      .min_hi(min_hi),
      .hr_lo(hr_lo),
      .hr_hi(hr_hi),
      .blink_mask(blink_mask),
      .seg(seg),
      .dp(dp),
      .an(an)
   );

   always #5 clk = ~clk;

   // model: m = clocks since reset; shown_m = state visible on outputs
   int         m = 0;
   int         shown_m = -1;
   logic [7:0] sh [6];
   logic [6:0] exp_seg = 7'h7F;
   logic       exp_dp = 1'b1;
   logic [5:0] exp_an = 6'h3F;
   logic [6:0] dtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   function automatic int slot_of(input int k);
      return (k / SD) % 6;
   endfunction

   function automatic logic [6:0] dec(input logic [7:0] v);
      if (v > 8'd9) return 7'h3F;
      return dtab[v[3:0]];
   endfunction

   function automatic logic [5:0] an_of(input int k, input logic [5:0] mask,
                                        input logic [7:0] h5);
      int s;
      bit off;
      s   = slot_of(k);
      off = ((k % SD) < DC) || ((((k / FR) / BF) % 2 == 1) && mask[s]);
      if (LZB && s == 5 && h5 == 8'd0) off = 1'b1;
      return off ? 6'h3F : ~(6'b000001 << s);
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m       <= 0;
         shown_m <= -1;
         exp_seg <= 7'h7F;
         exp_dp  <= 1'b1;
         exp_an  <= 6'h3F;
         for (int i = 0; i < 6; i++) sh[i] <= 8'd0;
      end else begin
         exp_seg <= dec(sh[slot_of(m)]);
         exp_dp  <= !(slot_of(m) == 2 || slot_of(m) == 4);
         exp_an  <= an_of(m, blink_mask, sh[5]);
         shown_m <= m;
         m       <= m + 1;
         if ((m + 1) % FR == 0) begin
            sh[0] <= sec_lo;
            sh[1] <= sec_hi;
            sh[2] <= min_lo;
            sh[3] <= min_hi;
            sh[4] <= hr_lo;
            sh[5] <= hr_hi;
         end
      end
   end

   function automatic logic [7:0] rand_digit();
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) return 8'(r);
      return 8'($urandom);
   endfunction

   task automatic set_all(input logic [7:0] h1, input logic [7:0] h0,
                          input logic [7:0] m1, input logic [7:0] m0,
                          input logic [7:0] s1, input logic [7:0] s0);
      hr_hi  = h1;
      hr_lo  = h0;
      min_hi = m1;
      min_lo = m0;
      sec_hi = s1;
      sec_lo = s0;
   endtask

   task automatic wait_slot(input int s, input int d);
      int  n;
      bit  hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 400) begin
         @(negedge clk);
         n++;
         hit = (shown_m >= 0) && (slot_of(shown_m) == s) && (shown_m % SD == d);
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait_slot: slot %0d div %0d not reached, m=%0d after %0d cycles",
                  s, d, shown_m, n);
      end
   endtask

   task automatic test_reset();
      set_all(8'd2, 8'd3, 8'd5, 8'd9, 8'd4, 8'd1);
      repeat (3) @(negedge clk);
      checks++;
      if ({seg, dp, an} !== {7'h7F, 1'b1, 6'h3F}) begin
         errors++;
         $display("FAIL reset_hold: seg=%h dp=%b an=%h, required seg=7f dp=1 an=3f", seg, dp, an);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (seg !== 7'h40 || an !== 6'h3F) begin
         errors++;
         $display("FAIL reset_first: seg=%h an=%h, required seg=40 an=3f", seg, an);
      end
      @(negedge clk);
      checks++;
      if (seg !== 7'h40 || an !== 6'h3E) begin
         errors++;
         $display("FAIL reset_slot0: seg=%h an=%h, required seg=40 an=3e", seg, an);
      end
      wait_slot(1, 0);
      wait_slot(3, 2);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({seg, dp, an} !== {7'h7F, 1'b1, 6'h3F}) begin
         errors++;
         $display("FAIL reset_async: seg=%h dp=%b an=%h, required seg=7f dp=1 an=3f", seg, dp, an);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_slot(0, 1);
      checks++;
      if (seg !== 7'h40 || an !== 6'h3E) begin
         errors++;
         $display("FAIL reset_zero_shadow: seg=%h an=%h, required seg=40 an=3e", seg, an);
      end
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         checks++;
         if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
            errors++;
            $display("FAIL reset_model m=%0d: seg=%h dp=%b an=%h, required seg=%h dp=%b an=%h",
                     shown_m, seg, dp, an, exp_seg, exp_dp, exp_an);
         end
      end
   endtask

   task automatic test_scan_order();
      blink_mask = 6'd0;
      set_all(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
      wait_slot(1, 0);
      wait_slot(0, 0);
      checks++;
      if (an !== 6'h3F || seg !== 7'h02) begin
         errors++;
         $display("FAIL scan_dead: an=%h seg=%h, required an=3f seg=02", an, seg);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (an !== 6'h3E || seg !== 7'h02) begin
            errors++;
            $display("FAIL scan_slot0: an=%h seg=%h, required an=3e seg=02", an, seg);
         end
      end
      wait_slot(2, 1);
      checks++;
      if (seg !== 7'h19 || dp !== 1'b0 || an !== 6'h3B) begin
         errors++;
         $display("FAIL scan_slot2: seg=%h dp=%b an=%h, required seg=19 dp=0 an=3b", seg, dp, an);
      end
      wait_slot(5, 1);
      checks++;
      if (seg !== 7'h79 || dp !== 1'b1 || an !== 6'h1F) begin
         errors++;
         $display("FAIL scan_slot5: seg=%h dp=%b an=%h, required seg=79 dp=1 an=1f", seg, dp, an);
      end
      for (int i = 0; i < FR; i++) begin
         @(negedge clk);
         checks++;
         if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
            errors++;
            $display("FAIL scan_model m=%0d: seg=%h dp=%b an=%h, required seg=%h dp=%b an=%h",
                     shown_m, seg, dp, an, exp_seg, exp_dp, exp_an);
         end
      end
   endtask

   task automatic test_invalid();
      set_all(8'd1, 8'd2, 8'h13, 8'd4, 8'd5, 8'h0A);
      wait_slot(1, 0);
      wait_slot(0, 1);
      checks++;
      if (seg !== 7'h3F || an !== 6'h3E) begin
         errors++;
         $display("FAIL invalid_0a: seg=%h an=%h, required seg=3f an=3e", seg, an);
      end
      wait_slot(3, 1);
      checks++;
      if (seg !== 7'h3F || an !== 6'h37) begin
         errors++;
         $display("FAIL invalid_13: seg=%h an=%h, required seg=3f an=37", seg, an);
      end
   endtask

   task automatic test_snapshot();
      set_all(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5);
      wait_slot(1, 0);
      wait_slot(0, 1);
      checks++;
      if (seg !== 7'h12) begin
         errors++;
         $display("FAIL snap_before: seg=%h, required 12", seg);
      end
      wait_slot(2, 1);
      sec_lo = 8'd7;
      hr_hi  = 8'd2;
      wait_slot(5, 1);
      checks++;
      if (seg !== 7'h79) begin
         errors++;
         $display("FAIL snap_midframe: seg=%h, required 79", seg);
      end
      wait_slot(0, 1);
      checks++;
      if (seg !== 7'h78) begin
         errors++;
         $display("FAIL snap_after_s0: seg=%h, required 78", seg);
      end
      wait_slot(5, 1);
      checks++;
      if (seg !== 7'h24) begin
         errors++;
         $display("FAIL snap_after_s5: seg=%h, required 24", seg);
      end
   endtask

   task automatic test_blink();
      logic [5:0] want;
      bit         dark;
      blink_mask = 6'b000011;
      for (int f = 0; f < 8; f++) begin
         wait_slot(0, 2);
         dark = ((shown_m / FR) / BF) % 2 == 1;
         want = dark ? 6'h3F : 6'h3E;
         checks++;
         if (an !== want) begin
            errors++;
            $display("FAIL blink_s0 frame %0d: an=%h, required %h", shown_m / FR, an, want);
         end
         wait_slot(1, 2);
         want = dark ? 6'h3F : 6'h3D;
         checks++;
         if (an !== want) begin
            errors++;
            $display("FAIL blink_s1 frame %0d: an=%h, required %h", shown_m / FR, an, want);
         end
         wait_slot(2, 2);
         checks++;
         if (an !== 6'h3B) begin
            errors++;
            $display("FAIL blink_s2 frame %0d: an=%h, required 3b", shown_m / FR, an);
         end
      end
      blink_mask = 6'd0;
   endtask

   task automatic test_blank();
      logic [5:0] want;
      set_all(8'd0, 8'd9, 8'd0, 8'd5, 8'd0, 8'd0);
      wait_slot(1, 0);
      wait_slot(5, 0);
      for (int d = 0; d < SD; d++) begin
         if (d > 0) @(negedge clk);
         want = (LZB || d < DC) ? 6'h3F : 6'h1F;
         checks++;
         if (an !== want || seg !== 7'h40) begin
            errors++;
            $display("FAIL blank div %0d: an=%h seg=%h, required an=%h seg=40", d, an, seg, want);
         end
      end
      wait_slot(4, 1);
      checks++;
      if (seg !== 7'h10 || an !== 6'h2F || dp !== 1'b0) begin
         errors++;
         $display("FAIL blank_s4: seg=%h an=%h dp=%b, required seg=10 an=2f dp=0", seg, an, dp);
      end
   endtask

   task automatic test_random();
      set_all(rand_digit(), rand_digit(), rand_digit(),
              rand_digit(), rand_digit(), rand_digit());
      for (int i = 0; i < 30 * FR; i++) begin
         @(negedge clk);
         checks++;
         if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
            errors++;
            $display("FAIL random m=%0d: seg=%h dp=%b an=%h, required seg=%h dp=%b an=%h",
                     shown_m, seg, dp, an, exp_seg, exp_dp, exp_an);
         end
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 5))
               0: sec_lo = rand_digit();
               1: sec_hi = rand_digit();
               2: min_lo = rand_digit();
               3: min_hi = rand_digit();
               4: hr_lo  = rand_digit();
               default: hr_hi = ($urandom_range(0, 2) == 0) ? 8'd0 : rand_digit();
            endcase
         end
         if ($urandom_range(0, 15) == 0) blink_mask = 6'($urandom);
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_invalid();
      test_snapshot();
      test_blink();
      test_blank();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
